// File: rtl/ahb_decode_mux.sv
// AHB-Lite address decoder and response mux with a built-in default slave.
// Unmapped active transfers get a two-cycle ERROR; the last such address and a saturating count are kept.
//
//   state   | meaning
//   DS_OK   | default slave idle, zero-wait OKAY
//   DS_ERR1 | first ERROR cycle, HREADY low
//   DS_ERR2 | second ERROR cycle, HREADY high
`timescale 1ns/1ps
module ahb_decode_mux #(
    parameter int num_slaves = 3,
    parameter logic [num_slaves-1:0][31:0] SLAVE_BASE = {32'h5000_0000, 32'h4000_0000, 32'h0000_0000},
    parameter logic [num_slaves-1:0][31:0] SLAVE_MASK = {32'hF000_0000, 32'hF000_0000, 32'hC000_0000},
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                            HCLK,
    input  logic                            HRESETn,
    input  logic [31:0]                     HADDR,
    input  logic [1:0]                      HTRANS,
    output logic [num_slaves-1:0]           HSEL_SIGNALS,
    input  logic [num_slaves-1:0]           HREADYOUT_SIGNALS,
    input  logic [num_slaves-1:0]           HRESP_SIGNALS,
    input  logic [num_slaves-1:0][31:0]     HRDATA_SIGNALS,
    output logic                            HREADY,
    output logic                            HRESP,
    output logic [31:0]                     HRDATA,
    output logic [ERR_CNT_WIDTH-1:0]        ERR_COUNT,
    output logic [31:0]                     ERR_ADDR
);

    typedef enum logic [1:0] {
        DS_OK   = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_t;

    localparam logic [num_slaves:0] DSEL_DEF = {1'b1, {num_slaves{1'b0}}};

    ds_state_t             ds_state, ds_next;
    logic [num_slaves:0]   dsel;
    logic [num_slaves-1:0] hsel;
    logic                  hit;
    logic                  miss;
    logic                  accept_miss;
    logic                  ds_hready, ds_hresp;
    logic                  unused_htrans0;

    assign unused_htrans0 = HTRANS[0];

    // Lowest index wins when windows overlap, keeping HSEL one-hot.
    always_comb begin
        hsel = '0;
        hit  = 1'b0;
        for (int i = 0; i < num_slaves; i++) begin
            if (!hit && ((HADDR & SLAVE_MASK[i]) == SLAVE_BASE[i])) begin
                hsel[i] = 1'b1;
                hit     = 1'b1;
            end
        end
    end

    assign miss         = ~hit;
    assign HSEL_SIGNALS = hsel;
    assign accept_miss  = HREADY & HTRANS[1] & miss;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dsel <= DSEL_DEF;
        end else if (HREADY) begin
            dsel <= {miss, hsel};
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ds_state <= DS_OK;
        end else begin
            ds_state <= ds_next;
        end
    end

    always_comb begin
        ds_next = ds_state;
        case (ds_state)
            DS_OK:   if (accept_miss) ds_next = DS_ERR1;
            DS_ERR1: ds_next = DS_ERR2;
            DS_ERR2: ds_next = accept_miss ? DS_ERR1 : DS_OK;
            default: ds_next = DS_OK;
        endcase
    end

    always_comb begin
        ds_hready = 1'b1;
        ds_hresp  = 1'b0;
        case (ds_state)
            DS_ERR1: begin
                ds_hready = 1'b0;
                ds_hresp  = 1'b1;
            end
            DS_ERR2: ds_hresp = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        HREADY = 1'b0;
        HRESP  = 1'b0;
        HRDATA = '0;
        for (int i = 0; i < num_slaves; i++) begin
            HREADY = HREADY | (dsel[i] & HREADYOUT_SIGNALS[i]);
            HRESP  = HRESP  | (dsel[i] & HRESP_SIGNALS[i]);
            HRDATA = HRDATA | ({32{dsel[i]}} & HRDATA_SIGNALS[i]);
        end
        if (dsel[num_slaves]) begin
            HREADY = ds_hready;
            HRESP  = ds_hresp;
            HRDATA = 32'hDEAD_BEEF;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ERR_ADDR <= '0;
        end else if (accept_miss) begin
            ERR_ADDR <= HADDR;
        end
    end

    // Every pass through DS_ERR2 is a completed error response.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ERR_COUNT <= '0;
        end else if (ds_state == DS_ERR2 && ERR_COUNT != '1) begin
            ERR_COUNT <= ERR_COUNT + ERR_CNT_WIDTH'(1);
        end
    end

endmodule

// File: doc/ahb_decode_mux.md
# ahb_decode_mux

Parametrised AHB-Lite address decoder and response multiplexer for the single-master SoC bus, sitting between the master and `num_slaves` slaves. The address map is set by per-slave base/mask parameters. Any address that matches no slave is routed to a built-in default slave, which returns the two-cycle AHB ERROR response. The block also records the last unmapped address and keeps a saturating decode-error count for software and debug.

## Interface
- `num_slaves`, 3: number of mapped slaves (1..16).
- `SLAVE_BASE`, {32'h5000_0000, 32'h4000_0000, 32'h0000_0000}: packed `[num_slaves-1:0][31:0]` base address per slave; index 0 is the rightmost entry.
- `SLAVE_MASK`, {32'hF000_0000, 32'hF000_0000, 32'hC000_0000}: packed `[num_slaves-1:0][31:0]` compare mask per slave; index 0 is the rightmost entry.
- `ERR_CNT_WIDTH`, 8: width of the error counter.
- `HCLK` in 1: bus clock. The block has one clock.
- `HRESETn` in 1: reset, asynchronous, active-low.
- `HADDR` in 32: address-phase address from the master.
- `HTRANS` in 2: transfer type from the master; bit 1 high means NONSEQ or SEQ.
- `HSEL_SIGNALS` out `num_slaves`: one-hot slave select, or all zero on a miss.
- `HREADYOUT_SIGNALS` in `num_slaves`: per-slave ready.
- `HRESP_SIGNALS` in `num_slaves`: per-slave response; 1 means ERROR.
- `HRDATA_SIGNALS` in `[num_slaves-1:0][31:0]`: per-slave read data.
- `HREADY` out 1: muxed ready to the master and slaves.
- `HRESP` out 1: muxed response to the master.
- `HRDATA` out 32: muxed read data to the master.
- `ERR_COUNT` out `ERR_CNT_WIDTH`: number of completed default-slave ERROR responses; saturating.
- `ERR_ADDR` out 32: `HADDR` of the most recent accepted active transfer that hit no slave.

## Operation
- **Decode (combinational).** Slave i matches when `(HADDR & SLAVE_MASK[i]) == SLAVE_BASE[i]`. If more than one slave matches, the lowest index wins, so `HSEL_SIGNALS` is always one-hot or zero. The decode does not depend on `HTRANS`.
- **Miss.** No slave matches.
- **Data-phase select.** Register `dsel` holds `num_slaves`+1 one-hot bits, with bit `num_slaves` selecting the default slave.
  - Loaded on each rising edge with `HREADY`=1.
  - Takes the index of the decoded slave, or the default bit on a miss.
  - Holds its value while `HREADY`=0.
- **Mapped slave selected.** `HREADY`, `HRESP` and `HRDATA` come from that slave's inputs.
- **Default slave selected.** `HRDATA` = 32'hDEADBEEF. The default-slave FSM drives `HREADY` and `HRESP`.
- **Default-slave FSM states:** DS_OK, DS_ERR1, DS_ERR2.
  - DS_OK: `HREADY`=1, `HRESP`=0.
  - DS_ERR1: `HREADY`=0, `HRESP`=1.
  - DS_ERR2: `HREADY`=1, `HRESP`=1.
- **FSM transitions.** Let "accepted active miss" mean `HREADY`=1 and `HTRANS[1]`=1 and miss.
  - DS_OK -> DS_ERR1 on an accepted active miss.
  - DS_ERR1 -> DS_ERR2, always.
  - DS_ERR2 -> DS_ERR1 on an accepted active miss. This covers back-to-back errors, since the next address phase is accepted in DS_ERR2.
  - DS_ERR2 -> DS_OK otherwise.
  - DS_OK stays in DS_OK otherwise.
- **Non-active miss.** An IDLE or BUSY transfer that misses selects the default slave but completes with zero wait states and an OKAY response.
- **`ERR_ADDR`.** Loaded with `HADDR` on every accepted active miss; otherwise it holds.
- **`ERR_COUNT`.** Increments on the edge leaving DS_ERR2. It saturates at all-ones and never wraps.
- **Reset.** On asynchronous assertion of `HRESETn`:
  - `dsel` goes to the default bit and the FSM goes to DS_OK, so the outputs are `HREADY`=1, `HRESP`=0, `HRDATA`=32'hDEADBEEF.
  - `ERR_COUNT`=0 and `ERR_ADDR`=0.
  - `HSEL_SIGNALS` follows `HADDR` even while in reset.
  - Reset during DS_ERR1 or DS_ERR2 aborts the error response and does not count it.

## Timing
- `HSEL_SIGNALS` has zero latency from `HADDR`.
- `HREADY`, `HRESP` and `HRDATA` are combinational from `dsel`, the FSM state and the slave inputs; there is no added pipeline stage.
- A mapped transfer takes one data-phase cycle plus the wait states inserted by the slave.
- An active miss has a data phase of exactly 2 cycles: DS_ERR1 then DS_ERR2.
- `ERR_ADDR` updates on the address-phase edge.
- `ERR_COUNT` becomes visible one cycle after DS_ERR2.

## Test plan
- **Reset.** Assert `HRESETn`=0 mid-cycle.
  - Immediately: `HREADY`=1, `HRESP`=0, `HRDATA`=32'hDEADBEEF, `ERR_COUNT`=0, `ERR_ADDR`=0.
  - With `HADDR`=32'h4000_0010: `HSEL_SIGNALS`=3'b010.
- **Mapped read with wait states.** NONSEQ read at 32'h4000_0004; slave 1 holds `HREADYOUT_SIGNALS[1]`=0 for 2 cycles, then returns 32'h1234_5678.
  - `HREADY` is low for 2 cycles, then `HRDATA`=32'h1234_5678 with `HRESP`=0.
  - `HSEL_SIGNALS` tracks the next `HADDR` throughout.
- **Unmapped access.** NONSEQ to 32'h6000_0000.
  - Data phase: (`HREADY`,`HRESP`) = (0,1) then (1,1).
  - `ERR_ADDR`=32'h6000_0000.
  - `ERR_COUNT`=1 one cycle after the error completes.
- **Idle miss, then back-to-back errors.**
  - IDLE to 32'h7000_0000 gives zero-wait OKAY and `ERR_COUNT` is unchanged.
  - Then NONSEQ to 32'h6000_0000 followed by SEQ to 32'h6000_0004: error pattern 0/1, 1/1, 0/1, 1/1; `ERR_ADDR`=32'h6000_0004; `ERR_COUNT`=2.
- **Saturation.** With `ERR_CNT_WIDTH`=2, perform 5 unmapped NONSEQ transfers: `ERR_COUNT` reads 1, 2, 3, 3, 3.
- **Reset mid-error, and overlap priority.**
  - Assert reset while in DS_ERR1: outputs return to reset values and `ERR_COUNT` is not incremented.
  - With `SLAVE_BASE`/`SLAVE_MASK` set so slaves 0 and 1 overlap: `HSEL_SIGNALS` selects slave 0.
